// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - sequencing controller for a multi-cycle RV M-extension multiply/divide unit
//
// Purpose:
//   Accepts one MUL/DIV op from dispatch, drives the external datapath through
//   start/step/kill strobes, and presents the finished result's tag to
//   writeback with a valid/ready handshake. Only one op is in flight at a time;
//   a new op may be accepted in the same cycle the previous result retires.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     dispatch handshake
//   in_funct3, in_word    op descriptor (funct3[2]=1 selects divide/remainder)
//   in_tag                destination ROB tag
//   flush                 kills any op in flight, blocks acceptance
//   dp_divzero            divisor==0 from the datapath, valid in the accept cycle
//   dp_start/step/kill    datapath control strobes
//   out_valid/out_ready   writeback handshake
//   out_tag               ROB tag of the completing op
//   out_funct3, out_word  op descriptor retained for writeback result selection
//   busy                  controller not idle

module mdu_seq_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 64,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_word,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  input  logic             dp_divzero,
  output logic             dp_start,
  output logic             dp_step,
  output logic             dp_kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_funct3,
  output logic             out_word,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [6:0] L_MUL_CNT  = 7'(MUL_LAT);
  localparam logic [6:0] L_DIV_CNT  = 7'(DIV_LAT);
  localparam logic [6:0] L_DIVW_CNT = 7'd32;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [6:0]         r_cnt;
  logic [6:0]         w_cnt_nxt;
  logic [TAG_W-1:0]   r_tag;
  logic [2:0]         r_funct3;
  logic               r_word;
  logic               w_accept;
  logic               w_in_ready;

  // DONE with out_ready frees the slot in the same cycle, so a back-to-back
  // op is accepted without a bubble. Flush always blocks acceptance.
  assign w_in_ready = !flush && ((r_state == S_IDLE) ||
                                 ((r_state == S_DONE) && out_ready));
  assign w_accept   = in_valid && w_in_ready;

  assign in_ready   = w_in_ready;
  assign dp_start   = w_accept;
  assign dp_step    = (r_state == S_MUL) || (r_state == S_DIV);
  assign dp_kill    = flush && (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_tag    = r_tag;
  assign out_funct3 = r_funct3;
  assign out_word   = r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 7'd0;
    end else if (w_accept) begin
      if (!in_funct3[2]) begin
        w_state_nxt = S_MUL;
        w_cnt_nxt   = L_MUL_CNT;
      end else if (dp_divzero) begin
        // Datapath produces the architectural div-by-zero result itself.
        w_state_nxt = S_DONE;
        w_cnt_nxt   = 7'd0;
      end else begin
        w_state_nxt = S_DIV;
        w_cnt_nxt   = in_word ? L_DIVW_CNT : L_DIV_CNT;
      end
    end else begin
      case (r_state)
        S_MUL, S_DIV: begin
          // <= 1 rather than == 1 so the counter can never wrap.
          if (r_cnt <= 7'd1) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = 7'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 7'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Op descriptor is captured only on accept, so a stalled in_valid cannot
  // disturb the result currently waiting in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag    <= '0;
      r_funct3 <= 3'd0;
      r_word   <= 1'b0;
    end else if (w_accept) begin
      r_tag    <= in_tag;
      r_funct3 <= in_funct3;
      r_word   <= in_word;
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb/tb_mdu_seq_ctrl.sv - directed self-checking bench for mdu_seq_ctrl
module tb_mdu_seq_ctrl;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_funct3 = 3'd0;
  logic             in_word = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             dp_divzero = 1'b0;
  logic             dp_start;
  logic             dp_step;
  logic             dp_kill;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_funct3;
  logic             out_word;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  mdu_seq_ctrl #(.MUL_LAT(4), .DIV_LAT(64), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_word(in_word), .in_tag(in_tag),
    .flush(flush), .dp_divzero(dp_divzero),
    .dp_start(dp_start), .dp_step(dp_step), .dp_kill(dp_kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_funct3(out_funct3), .out_word(out_word), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (dp_step !== 1'b0 || dp_kill !== 1'b0) begin n_err++; $display("FAIL reset_dp got=%0b%0b exp=00", dp_step, dp_kill); end
    n_cmp++; if (out_tag !== 6'd0 || out_funct3 !== 3'd0 || out_word !== 1'b0) begin n_err++; $display("FAIL reset_regs got=%0d/%0d/%0b exp=0/0/0", out_tag, out_funct3, out_word); end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    in_valid = 1'b1;
    #1;
    n_cmp++; if (dp_start !== 1'b1) begin n_err++; $display("FAIL post_reset_dp_start_hi got=%0b exp=1", dp_start); end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (dp_start !== 1'b0) begin n_err++; $display("FAIL post_reset_dp_start_lo got=%0b exp=0", dp_start); end
  endtask

  task automatic test_mul();
    tick();
    in_valid = 1'b1; in_funct3 = 3'b000; in_word = 1'b0; in_tag = 6'd5; out_ready = 1'b1;
    #1;
    n_cmp++; if (dp_start !== 1'b1) begin n_err++; $display("FAIL mul_start got=%0b exp=1", dp_start); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_cmp++; if (dp_step !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL mul_step_c%0d got=%0b%0b%0b exp=101", c, dp_step, out_valid, busy); end
      tick();
    end
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 6'd5 || dp_step !== 1'b0) begin n_err++; $display("FAIL mul_done got=%0b/%0d/%0b exp=1/5/0", out_valid, out_tag, dp_step); end
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mul_idle got=%0b%0b exp=00", busy, out_valid); end
  endtask

  task automatic test_div();
    int lat;
    int steps;
    in_valid = 1'b1; in_funct3 = 3'b100; in_word = 1'b1; in_tag = 6'd7; dp_divzero = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; steps = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (dp_step === 1'b1) steps++;
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divw_latency got=%0d exp=33", lat); end
    n_cmp++; if (steps !== 32) begin n_err++; $display("FAIL divw_steps got=%0d exp=32", steps); end
    n_cmp++; if (out_tag !== 6'd7 || out_word !== 1'b1) begin n_err++; $display("FAIL divw_tag got=%0d/%0b exp=7/1", out_tag, out_word); end
    // Back-to-back DIV accepted in the DIVW retire cycle.
    in_valid = 1'b1; in_funct3 = 3'b101; in_word = 1'b0; in_tag = 6'd8;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || dp_start !== 1'b1) begin n_err++; $display("FAIL div_b2b_accept got=%0b%0b exp=11", in_ready, dp_start); end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL div_latency got=%0d exp=65", lat); end
    n_cmp++; if (out_tag !== 6'd8 || out_funct3 !== 3'b101 || out_word !== 1'b0) begin n_err++; $display("FAIL div_desc got=%0d/%0d/%0b exp=8/5/0", out_tag, out_funct3, out_word); end
    tick();
  endtask

  task automatic test_divzero();
    in_valid = 1'b1; in_funct3 = 3'b101; in_word = 1'b0; in_tag = 6'd9; dp_divzero = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (dp_start !== 1'b1) begin n_err++; $display("FAIL dz_start got=%0b exp=1", dp_start); end
    tick();
    in_valid = 1'b0; dp_divzero = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || dp_step !== 1'b0 || out_tag !== 6'd9) begin n_err++; $display("FAIL dz_done got=%0b/%0b/%0d exp=1/0/9", out_valid, dp_step, out_tag); end
    tick();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dz_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_funct3 = 3'b000; in_word = 1'b0; in_tag = 6'd10; out_ready = 1'b0;
    tick();
    in_tag = 6'd11; in_funct3 = 3'b001; in_word = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_tag !== 6'd10 || out_funct3 !== 3'b000) begin n_err++; $display("FAIL stall_hold_c%0d got=%0b/%0d/%0d exp=1/10/0", c, out_valid, out_tag, out_funct3); end
      n_cmp++; if (in_ready !== 1'b0 || dp_start !== 1'b0) begin n_err++; $display("FAIL stall_block_c%0d got=%0b%0b exp=00", c, in_ready, dp_start); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || dp_start !== 1'b1 || out_tag !== 6'd10) begin n_err++; $display("FAIL b2b_retire got=%0b%0b/%0d exp=11/10", in_ready, dp_start, out_tag); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_tag !== 6'd11 || out_valid !== 1'b0 || dp_step !== 1'b1) begin n_err++; $display("FAIL b2b_next got=%0d/%0b/%0b exp=11/0/1", out_tag, out_valid, dp_step); end
    for (int c = 0; c < 4; c++) tick();
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 6'd11 || out_word !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%0b/%0d/%0b exp=1/11/1", out_valid, out_tag, out_word); end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    bit seen_old;
    flush = 1'b1;
    #1;
    n_cmp++; if (dp_kill !== 1'b0) begin n_err++; $display("FAIL flush_idle_kill got=%0b exp=0", dp_kill); end
    flush = 1'b0;
    in_valid = 1'b1; in_funct3 = 3'b100; in_word = 1'b0; in_tag = 6'd12; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_funct3 = 3'b000; in_tag = 6'd13; flush = 1'b1;
    #1;
    n_cmp++; if (dp_kill !== 1'b1 || in_ready !== 1'b0 || dp_start !== 1'b0) begin n_err++; $display("FAIL flush_kill got=%0b%0b%0b exp=100", dp_kill, in_ready, dp_start); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || dp_start !== 1'b1) begin n_err++; $display("FAIL flush_after got=%0b%0b%0b exp=011", busy, in_ready, dp_start); end
    tick();
    in_valid = 1'b0;
    lat = 1; seen_old = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    if (out_valid === 1'b1 && out_tag === 6'd12) seen_old = 1'b1;
    n_cmp++; if (seen_old !== 1'b0 || out_tag !== 6'd13) begin n_err++; $display("FAIL flush_tag got=%0d exp=13", out_tag); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL flush_next_latency got=%0d exp=5", lat); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1; in_funct3 = 3'b100; in_word = 1'b0; in_tag = 6'd14; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || dp_step !== 1'b0 || out_valid !== 1'b0 || out_tag !== 6'd0) begin n_err++; $display("FAIL rst_mid got=%0b%0b%0b/%0d exp=000/0", busy, dp_step, out_valid, out_tag); end
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_funct3 = 3'b011; in_tag = 6'd20;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 5 || out_tag !== 6'd20) begin n_err++; $display("FAIL rst_mul_after got=%0d/%0d exp=5/20", lat, out_tag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
